// File: rtl/hearts_pkg.sv
// Shared types and constants for the hearts controller.
package hearts_pkg;

  // Controller state encoding; code 2'd3 is illegal and recovers to PLAY.
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HURT = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int HEARTS_W           = 2;
  localparam int MAX_HEARTS_DEFAULT = 3;

  // Bits needed to hold values 0..v (at least one bit).
  function automatic int count_w(input int v);
    if (v <= 1) begin
      return 1;
    end
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter that steps once per tick and stops at zero.
module frame_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load has priority over tick; the counter holds at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/hearts_controller.sv
// Player health manager: damage, healing, invulnerability blink and game over.
module hearts_controller
  import hearts_pkg::*;
#(
  parameter int MAX_HEARTS    = MAX_HEARTS_DEFAULT,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                hit,
  input  logic                heal,
  input  logic                restart,
  output logic [HEARTS_W-1:0] num_hearts,
  output logic                invincible,
  output logic                blink,
  output logic                hit_ack,
  output logic                game_over
);

  localparam int                  BLINK_W    = count_w(BLINK_FRAMES);
  localparam logic [HEARTS_W-1:0] FULL       = HEARTS_W'(MAX_HEARTS);
  localparam logic [HEARTS_W-1:0] ONE        = HEARTS_W'(1);
  localparam logic [7:0]          INV_VAL    = 8'(INVULN_FRAMES);
  localparam logic [BLINK_W-1:0]  BLINK_VAL  = BLINK_W'(BLINK_FRAMES);

  state_t              state_reg, state_next;
  logic [HEARTS_W-1:0] hearts_reg, hearts_next;
  logic                blink_reg, blink_next;
  logic                hit_ack_reg, hit_ack_next;
  logic                invincible_reg, game_over_reg;

  logic               inv_load, inv_tick, inv_zero;
  logic [7:0]         inv_value, inv_cnt;
  logic               blink_load, blink_tick, blink_zero;
  logic [BLINK_W-1:0] blink_value, blink_cnt;

  frame_countdown #(.W(8)) u_inv_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (inv_load),
    .value (inv_value),
    .tick  (inv_tick),
    .count (inv_cnt),
    .zero  (inv_zero)
  );

  frame_countdown #(.W(BLINK_W)) u_blink_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (blink_load),
    .value (blink_value),
    .tick  (blink_tick),
    .count (blink_cnt),
    .zero  (blink_zero)
  );

  // Next-state, heart count, blink phase and counter control.
  always_comb begin
    state_next   = state_reg;
    hearts_next  = hearts_reg;
    blink_next   = blink_reg;
    hit_ack_next = 1'b0;
    inv_load     = 1'b0;
    inv_value    = '0;
    inv_tick     = 1'b0;
    blink_load   = 1'b0;
    blink_value  = '0;
    blink_tick   = 1'b0;

    if (restart) begin
      // Restart drops any same-cycle hit or heal.
      state_next  = PLAY;
      hearts_next = FULL;
      blink_next  = 1'b0;
      inv_load    = 1'b1;
      blink_load  = 1'b1;
    end else begin
      case (state_reg)
        PLAY: begin
          blink_next = 1'b0;
          if (hit) begin
            if (hearts_reg > ONE) begin
              hearts_next  = hearts_reg - ONE;
              hit_ack_next = 1'b1;
              state_next   = HURT;
              inv_load     = 1'b1;
              inv_value    = INV_VAL;
              blink_load   = 1'b1;
              blink_value  = BLINK_VAL;
              blink_next   = 1'b1;
            end else if (hearts_reg == ONE) begin
              hearts_next  = '0;
              hit_ack_next = 1'b1;
              state_next   = OVER;
            end else begin
              // Zero hearts while playing should not occur; fall into OVER quietly.
              state_next = OVER;
            end
          end else if (heal && (hearts_reg < FULL)) begin
            hearts_next = hearts_reg + ONE;
          end
        end
        HURT: begin
          // Hits are ignored while invulnerable; heals still apply.
          if (heal && (hearts_reg < FULL)) begin
            hearts_next = hearts_reg + ONE;
          end
          if (frame_tick) begin
            if (inv_zero || (inv_cnt == 8'd1)) begin
              state_next = PLAY;
              blink_next = 1'b0;
              inv_load   = 1'b1;
              blink_load = 1'b1;
            end else begin
              inv_tick = 1'b1;
              if (blink_zero || (blink_cnt == BLINK_W'(1))) begin
                blink_load  = 1'b1;
                blink_value = BLINK_VAL;
                blink_next  = ~blink_reg;
              end else begin
                blink_tick = 1'b1;
              end
            end
          end
        end
        OVER: begin
          hearts_next = '0;
        end
        default: begin
          state_next  = PLAY;
          hearts_next = FULL;
          blink_next  = 1'b0;
          inv_load    = 1'b1;
          blink_load  = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= PLAY;
      hearts_reg     <= FULL;
      blink_reg      <= 1'b0;
      hit_ack_reg    <= 1'b0;
      invincible_reg <= 1'b0;
      game_over_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hearts_reg     <= hearts_next;
      blink_reg      <= blink_next;
      hit_ack_reg    <= hit_ack_next;
      invincible_reg <= (state_next == HURT);
      game_over_reg  <= (state_next == OVER);
    end
  end

  assign num_hearts = hearts_reg;
  assign invincible = invincible_reg;
  assign blink      = blink_reg;
  assign hit_ack    = hit_ack_reg;
  assign game_over  = game_over_reg;

endmodule

// File: tb/tb_hearts_controller.sv
// Self-checking bench for hearts_controller against a frame-count model.
module tb_hearts_controller;

  localparam int MAXH   = 3;
  localparam int INVULN = 4;
  localparam int BLINKF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic       heal = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] num_hearts;
  logic       invincible, blink, hit_ack, game_over;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: hearts, mode (0 play, 1 hurt, 2 over), frames since the accepted hit.
  int  m_hearts = MAXH;
  int  m_mode = 0;
  int  m_k = 0;
  bit  m_ack = 0;

  hearts_controller #(
    .MAX_HEARTS    (MAXH),
    .INVULN_FRAMES (INVULN),
    .BLINK_FRAMES  (BLINKF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hit        (hit),
    .heal       (heal),
    .restart    (restart),
    .num_hearts (num_hearts),
    .invincible (invincible),
    .blink      (blink),
    .hit_ack    (hit_ack),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  wire [5:0] obs = {num_hearts, invincible, blink, hit_ack, game_over};

  function automatic logic [5:0] exp_vec();
    logic inv, blk, go;
    inv = (m_mode == 1);
    blk = inv && (((m_k / BLINKF) % 2) == 0);
    go  = (m_mode == 2);
    return {2'(m_hearts), inv, blk, m_ack, go};
  endfunction

  // Apply one cycle of inputs and advance the model by the same rules.
  task automatic step(input bit r, input bit t, input bit h, input bit he, input bit rs);
    reset = r; frame_tick = t; hit = h; heal = he; restart = rs;
    @(posedge clk);
    cyc++;
    if (r || rs) begin
      m_hearts = MAXH; m_mode = 0; m_k = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      case (m_mode)
        0: begin
          if (h) begin
            if (m_hearts > 1) begin
              m_hearts--; m_ack = 1; m_mode = 1; m_k = 0;
            end else if (m_hearts == 1) begin
              m_hearts = 0; m_ack = 1; m_mode = 2;
            end else begin
              m_mode = 2;
            end
          end else if (he && m_hearts < MAXH) begin
            m_hearts++;
          end
        end
        1: begin
          if (he && m_hearts < MAXH) m_hearts++;
          if (t) begin
            m_k++;
            if (m_k >= INVULN) m_mode = 0;
          end
        end
        default: m_hearts = 0;
      endcase
    end
    #1;
    reset = 0; frame_tick = 0; hit = 0; heal = 0; restart = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
    checks++;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
      checks++;
    end
    if (obs !== 6'b11_0000) begin errors++; $display("FAIL reset_const: got %b want %b", obs, 6'b11_0000); end
    checks++;
  endtask

  task automatic test_hurt_sequence();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    if (obs !== 6'b10_1110) begin errors++; $display("FAIL hit_accept: got %b want %b", obs, 6'b10_1110); end
    checks++;
    step(0, 0, 0, 0, 0);
    if (obs !== exp_vec()) begin errors++; $display("FAIL ack_one_cycle cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
    checks++;
    for (int i = 0; i < INVULN; i++) begin
      step(0, 1, 0, 0, 0);
      if (obs !== exp_vec()) begin errors++; $display("FAIL hurt_tick%0d cyc %0d: got %b want %b", i + 1, cyc, obs, exp_vec()); end
      checks++;
      if (i == 1 && blink !== 1'b0) begin errors++; $display("FAIL blink_half: got %b want 0", blink); end
      if (i == 1) checks++;
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin errors++; $display("FAIL hurt_idle cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
      checks++;
    end
    if (obs !== 6'b10_0000) begin errors++; $display("FAIL hurt_expire: got %b want %b", obs, 6'b10_0000); end
    checks++;
  endtask

  task automatic test_hit_during_hurt();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < INVULN; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      if (obs !== exp_vec()) begin errors++; $display("FAIL hit_in_hurt cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
      checks++;
    end
    if (num_hearts !== 2'd2 || hit_ack !== 1'b0) begin errors++; $display("FAIL hit_final_tick: got %0d/%b want 2/0", num_hearts, hit_ack); end
    checks++;
    step(0, 0, 1, 0, 0);
    if (num_hearts !== 2'd1 || hit_ack !== 1'b1) begin errors++; $display("FAIL hit_after_expire: got %0d/%b want 1/1", num_hearts, hit_ack); end
    checks++;
  endtask

  task automatic test_game_over();
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(0, 0, 1, 0, 0);
      if (obs !== exp_vec()) begin errors++; $display("FAIL go_hit%0d cyc %0d: got %b want %b", n, cyc, obs, exp_vec()); end
      checks++;
      for (int i = 0; i < INVULN; i++) step(0, 1, 0, 0, 0);
    end
    if (num_hearts !== 2'd0 || game_over !== 1'b1) begin errors++; $display("FAIL go_enter: got %0d/%b want 0/1", num_hearts, game_over); end
    checks++;
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    if (obs !== exp_vec()) begin errors++; $display("FAIL go_ignore cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
    checks++;
    step(0, 0, 1, 1, 1);
    if (obs !== 6'b11_0000) begin errors++; $display("FAIL go_restart: got %b want %b", obs, 6'b11_0000); end
    checks++;
  endtask

  task automatic test_heal();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    if (num_hearts !== 2'd3) begin errors++; $display("FAIL heal_sat: got %0d want 3", num_hearts); end
    checks++;
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < INVULN; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    if (num_hearts !== 2'd1 || hit_ack !== 1'b1) begin errors++; $display("FAIL hit_heal_same: got %0d/%b want 1/1", num_hearts, hit_ack); end
    checks++;
    step(0, 0, 0, 1, 0);
    if (num_hearts !== 2'd2 || invincible !== 1'b1) begin errors++; $display("FAIL heal_in_hurt: got %0d/%b want 2/1", num_hearts, invincible); end
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL heal_model cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
    checks++;
  endtask

  task automatic test_reset_mid_hurt();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    if (obs !== 6'b11_0000) begin errors++; $display("FAIL reset_mid_hurt: got %b want %b", obs, 6'b11_0000); end
    checks++;
    step(0, 1, 0, 0, 0);
    if (obs !== exp_vec()) begin errors++; $display("FAIL tick_after_reset cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 79) == 0));
      if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc %0d: got %b want %b", cyc, obs, exp_vec()); end
      checks++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hurt_sequence();
    test_hit_during_hurt();
    test_game_over();
    test_heal();
    test_reset_mid_hurt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
